// File: rtl/adc_tone_monitor.sv
// adc_tone_monitor: windowed peak / upward zero-crossing statistics over 8-lane 16-bit AXI-Stream words
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            run measurement windows while high
//   s_axis_tdata      eight signed samples, lane 0 ([15:0]) earliest
//   s_axis_tvalid     word valid
//   s_axis_tready     high only while a window is collecting words
//   meas_valid        one-cycle pulse, result outputs updated at the same edge
//   peak_max/min      signed extremes over the window
//   xcount            upward crossings (saturating)
//   first_x/last_x    sample index of first/last crossing, 16'hFFFF if none
module adc_tone_monitor #(
    parameter int WIN_WORDS = 128,
    parameter logic signed [15:0] HYST = 16'sh0400
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic         meas_valid,
    output logic [15:0]  peak_max,
    output logic [15:0]  peak_min,
    output logic [15:0]  xcount,
    output logic [15:0]  first_x,
    output logic [15:0]  last_x
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
    state_t state, state_nx;
    logic         hs, last_word, clr;
    logic [13:0]  widx;
    logic         a_valid;
    logic [127:0] a_data;
    logic [12:0]  a_idx;
    logic signed [15:0] pmax, pmin, n_max, n_min, smp;
    logic [15:0]  cnt, first, last, n_cnt, n_first, n_last, idx;
    logic         armed, n_armed;

    assign s_axis_tready = (state == RUN);
    assign hs = s_axis_tvalid && s_axis_tready;
    assign last_word = (widx == 14'(WIN_WORDS - 1));
    // Accumulators are held clear outside a window, re-cleared at report and on abort.
    assign clr = (state == IDLE) || (state == REPORT) || (state == RUN && !enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable ? RUN : IDLE;
            RUN:     state_nx = !enable ? IDLE : (hs && last_word) ? DRAIN : RUN;
            DRAIN:   state_nx = REPORT;
            REPORT:  state_nx = enable ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage A: register the accepted word with its word index; an abort discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx    <= '0;
            a_valid <= 1'b0;
            a_data  <= '0;
            a_idx   <= '0;
        end else begin
            widx    <= clr ? 14'd0 : hs ? widx + 14'd1 : widx;
            a_valid <= hs && enable;
            if (hs) begin
                a_data <= s_axis_tdata;
                a_idx  <= widx[12:0];
            end
        end
    end

    // Lanes are folded in time order so arming in one lane can feed a crossing in a later lane.
    always_comb begin
        n_max   = pmax;
        n_min   = pmin;
        n_cnt   = cnt;
        n_first = first;
        n_last  = last;
        n_armed = armed;
        smp     = '0;
        idx     = '0;
        for (int i = 0; i < 8; i++) begin
            smp = a_data[16*i +: 16];
            idx = {a_idx, 3'(i)};
            n_max = (smp > n_max) ? smp : n_max;
            n_min = (smp < n_min) ? smp : n_min;
            if (smp <= -HYST) begin
                n_armed = 1'b1;
            end else if (n_armed && smp >= HYST) begin
                n_cnt   = (n_cnt == 16'hFFFF) ? n_cnt : n_cnt + 16'd1;
                n_first = (n_first == 16'hFFFF) ? idx : n_first;
                n_last  = idx;
                n_armed = 1'b0;
            end
        end
    end

    // Stage B: accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            pmax  <= 16'sh8000;
            pmin  <= 16'sh7FFF;
            cnt   <= '0;
            first <= 16'hFFFF;
            last  <= 16'hFFFF;
            armed <= 1'b0;
        end else if (a_valid) begin
            pmax  <= n_max;
            pmin  <= n_min;
            cnt   <= n_cnt;
            first <= n_first;
            last  <= n_last;
            armed <= n_armed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            peak_max   <= '0;
            peak_min   <= '0;
            xcount     <= '0;
            first_x    <= 16'hFFFF;
            last_x     <= 16'hFFFF;
        end else begin
            meas_valid <= (state == REPORT);
            if (state == REPORT) begin
                peak_max <= pmax;
                peak_min <= pmin;
                xcount   <= cnt;
                first_x  <= first;
                last_x   <= last;
            end
        end
    end
endmodule

// File: doc/adc_tone_monitor.md
# adc_tone_monitor

Stream-side measurement block for the sine test path. It consumes 128-bit AXI-Stream words of eight signed 16-bit samples, the same packing our DAC pattern generators emit, and accumulates statistics over a fixed window of words. At the end of each window it reports peak maximum, peak minimum, upward zero-crossing count and first/last crossing sample indices, with a one-cycle `meas_valid` pulse. It sits on the ADC capture or loopback path so software can check tone frequency and amplitude.

## Interface
- `WIN_WORDS`, default 128: words per measurement window; range 2..8192, so sample indices fit in 16 bits.
- `HYST`, default 16'h0400: crossing hysteresis, positive signed.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run measurement windows while high.
- `s_axis_tdata`  in  128  eight samples; `[15:0]` is lane 0, the earliest sample; `[127:112]` is lane 7, the latest.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tready`  out  1  block accepts a word.
- `meas_valid`  out  1  one-cycle pulse; result outputs are updated at the same edge.
- `peak_max`  out  16  signed maximum sample in the window.
- `peak_min`  out  16  signed minimum sample in the window.
- `xcount`  out  16  upward crossings in the window, saturating at 16'hFFFF.
- `first_x`  out  16  sample index of the first crossing, or 16'hFFFF if none.
- `last_x`  out  16  sample index of the last crossing, or 16'hFFFF if none.

## Operation
- FSM states and transitions:
  - IDLE goes to RUN when `enable` is high.
  - RUN goes to DRAIN on the handshake of word WIN_WORDS-1.
  - DRAIN goes to REPORT.
  - REPORT goes to RUN if `enable` is high, otherwise to IDLE.
- `s_axis_tready` is 1 only in RUN. A handshake is `tvalid && tready`. A cycle with `tvalid`=0 in RUN changes nothing.
- Pipeline:
  - Stage A registers the accepted word plus its word index.
  - Stage B updates the accumulators from stage A.
- Sample index = word_index*8 + lane.
- Accumulator reset at window start (entry to RUN from IDLE or REPORT): `pmax`=16'h8000, `pmin`=16'h7FFF, `cnt`=0, `first`=`last`=16'hFFFF, `armed`=0, word_index=0.
- Per lane, evaluated in lane order 0..7 as a combinational chain within one word:
  - if sample <= -HYST then `armed`=1;
  - else if `armed` and sample >= HYST, this is a crossing: `cnt`+1 (saturating), `first` is set if still 16'hFFFF, `last` = index, `armed`=0.
- `armed` carries across words within a window and is cleared between windows.
- Max/min use signed compares across all eight lanes.
- REPORT copies the accumulators to the outputs, pulses `meas_valid` and re-clears the accumulators.
- `enable` low in RUN aborts the window:
  - on the next edge, go to IDLE and clear the accumulators;
  - no `meas_valid`, outputs hold their previous values;
  - a word already in stage A is discarded.
- `enable` low in DRAIN or REPORT: the window completes and reports, then the FSM goes to IDLE.
- Reset mid-operation: all state returns to reset values asynchronously, and any partial window is lost.

## Timing
- Reset values:
  - `s_axis_tready`=0, `meas_valid`=0;
  - `peak_max`=`peak_min`=0, `xcount`=0;
  - `first_x`=`last_x`=16'hFFFF;
  - FSM in IDLE.
- `s_axis_tready` rises one cycle after `enable` is seen high in IDLE.
- Report latency:
  - edge E0 accepts the last word;
  - E1: stage B absorbs it, FSM in REPORT;
  - E2: outputs loaded and `meas_valid` high for the cycle after E2.
- `s_axis_tready` is low for exactly two cycles between windows (DRAIN and REPORT).
- Maximum throughput is one word per cycle within a window. A window of WIN_WORDS back-to-back words takes WIN_WORDS+2 cycles.

## Test plan
- Back-to-back stream of the DAC 2 MHz table (16-word period, 128 samples, starting at 0x0000), WIN_WORDS=128, HYST=0x0400 -> `peak_max`=0x7FFC, `peak_min`=0x8004, `xcount`=7, `first_x`=129, `last_x`=897, `meas_valid` two edges after the 128th handshake.
- Same stream with random `tvalid` gaps (about 30% idle) -> identical results, `meas_valid` two edges after the final handshake.
- Constant DC word 16'h1000 on all lanes -> `xcount`=0, `first_x`=`last_x`=0xFFFF, `peak_max`=`peak_min`=0x1000.
- Alternating lanes 0x8000/0x7FFF in every word, WIN_WORDS=2 -> `xcount`=8, `first_x`=1, `last_x`=15.
- `enable` dropped after 50 words -> no `meas_valid`, previous outputs hold, `tready` low next cycle; re-enable gives a full fresh window.
- `rst_n` asserted mid-window -> all outputs at reset values immediately; after release and `enable`, the first report matches the first scenario.
